// File: rtl/gs_rom_loader_pkg.sv
// rtl/gs_rom_loader_pkg.sv - shared constants and types for the GS ROM loader
// Purpose: command/register constants, FSM state enum and FIFO entry layout.
// Ports: none (package).
package gs_loader_pkg;

  localparam logic [7:0] CMD_LOADER = 8'h0F;

  localparam logic [7:0] REG_A0   = 8'h00;
  localparam logic [7:0] REG_A1   = 8'h01;
  localparam logic [7:0] REG_A2   = 8'h02;
  localparam logic [7:0] REG_A3   = 8'h03;
  localparam logic [7:0] REG_DATA = 8'h04;
  localparam logic [7:0] REG_CTRL = 8'h05;
  localparam logic [7:0] REG_CLR  = 8'h06;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    GAP
  } loader_state_e;

  // Only the low three address bits are kept: lanes 0..5 fit, and 0x06
  // never enters the queue.
  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } loader_entry_t;

endpackage

// File: rtl/gs_rom_loader_if.sv
// rtl/gs_rom_loader_if.sv - MCU command and loader stream bundle
// Purpose: groups the MCU request inputs and the loader write-stream outputs.
// Ports: master drives mcu_* and observes loader_*/busy/overflow;
//        slave (the loader) consumes mcu_* and drives the rest.
interface gs_rom_loader_if;

  logic        mcu_req;
  logic [7:0]  mcu_cmd;
  logic [7:0]  mcu_addr;
  logic [7:0]  mcu_data;
  logic        loader_act;
  logic [31:0] loader_a;
  logic [7:0]  loader_d;
  logic        loader_wr;
  logic        busy;
  logic        overflow;

  modport master (
    output mcu_req, mcu_cmd, mcu_addr, mcu_data,
    input  loader_act, loader_a, loader_d, loader_wr, busy, overflow
  );

  modport slave (
    input  mcu_req, mcu_cmd, mcu_addr, mcu_data,
    output loader_act, loader_a, loader_d, loader_wr, busy, overflow
  );

endinterface

// File: rtl/gs_rom_loader_fifo.sv
// rtl/gs_rom_loader_fifo.sv - synchronous command FIFO
// Purpose: in-order queue; a push while full is accepted only if a pop
//          happens in the same cycle.
// Ports: clk_bus, reset_n, push/din, pop/dout, full, empty, count.
module loader_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                       clk_bus,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk_bus) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk_bus) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/gs_rom_loader.sv
// rtl/gs_rom_loader.sv - paced loader write-stream producer for General Sound
// Purpose: decodes CMD_LOADER register writes, queues them in order and
//          replays data bytes as WR_CYCLES-long strobes with GAP_CYCLES gaps.
// Ports: clk_bus, reset_n (sync, active-low), bus (slave modport: mcu_* in,
//        loader_act/loader_a/loader_d/loader_wr/busy/overflow out).
module gs_rom_loader
  import gs_loader_pkg::*;
#(
  parameter int WR_CYCLES  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_bus,
  input  logic             reset_n,
  gs_rom_loader_if.slave   bus
);

  localparam int CNT_MAX = (WR_CYCLES > GAP_CYCLES) ? WR_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  loader_state_e           state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [31:0]             a_q;
  logic [7:0]              d_q;
  logic                    wr_q;
  logic                    act_q;
  logic                    ovf_q;

  logic                    is_loader;
  logic                    queue_req;
  logic                    clr_req;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  loader_entry_t           wr_entry;
  loader_entry_t           rd_entry;

  assign is_loader = bus.mcu_req && (bus.mcu_cmd == CMD_LOADER);
  assign queue_req = is_loader && (bus.mcu_addr <= REG_CTRL);
  assign clr_req   = is_loader && (bus.mcu_addr == REG_CLR);
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
  // A full queue still takes the request when the FSM frees a slot this cycle.
  assign fifo_push = queue_req && (!fifo_full || fifo_pop);
  assign wr_entry  = '{addr: bus.mcu_addr[2:0], data: bus.mcu_data};

  loader_fifo #(
    .WIDTH ($bits(loader_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_bus (clk_bus),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (wr_entry),
    .pop     (fifo_pop),
    .dout    (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk_bus) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      d_q     <= '0;
      wr_q    <= 1'b0;
      act_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (clr_req) begin
        ovf_q <= 1'b0;
      end else if (queue_req && fifo_full && !fifo_pop) begin
        ovf_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (fifo_pop) begin
            case (rd_entry.addr)
              REG_A0[2:0]:   a_q[7:0]   <= rd_entry.data;
              REG_A1[2:0]:   a_q[15:8]  <= rd_entry.data;
              REG_A2[2:0]:   a_q[23:16] <= rd_entry.data;
              REG_A3[2:0]:   a_q[31:24] <= rd_entry.data;
              REG_DATA[2:0]: begin
                // With the loader inactive the byte is silently discarded.
                if (act_q) begin
                  d_q     <= rd_entry.data;
                  wr_q    <= 1'b1;
                  cnt_q   <= CNT_W'(WR_CYCLES - 1);
                  state_q <= STROBE;
                end
              end
              REG_CTRL[2:0]: act_q <= rd_entry.data[0];
              default: ;
            endcase
          end
        end
        STROBE: begin
          if (cnt_q == '0) begin
            wr_q    <= 1'b0;
            a_q     <= a_q + 32'd1;
            cnt_q   <= CNT_W'(GAP_CYCLES - 1);
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.loader_act = act_q;
  assign bus.loader_a   = a_q;
  assign bus.loader_d   = d_q;
  assign bus.loader_wr  = wr_q;
  assign bus.overflow   = ovf_q;
  assign bus.busy       = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_gs_rom_loader.sv
// tb/tb_gs_rom_loader.sv - self-checking bench for gs_rom_loader
module tb_gs_rom_loader;

  localparam int WR    = 4;
  localparam int GAP   = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  gs_rom_loader_if bus_if();

  gs_rom_loader #(
    .WR_CYCLES  (WR),
    .GAP_CYCLES (GAP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_bus (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Timeline model: a queue of pending entries plus the edge numbers at
  // which the current strobe started, the address bumps and the loader frees.
  logic [10:0] mq[$];
  logic [10:0] m_e;
  logic [31:0] m_a = '0;
  logic [7:0]  m_d = '0;
  logic        m_act = 1'b0;
  logic        m_ovf = 1'b0;
  int cyc = 0;
  int wr_start = -100;
  int inc_edge = -1;
  int fsm_end = -100;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!reset_n) begin
      mq.delete();
      m_a = '0; m_d = '0; m_act = 1'b0; m_ovf = 1'b0;
      wr_start = -100; inc_edge = -1; fsm_end = -100;
    end else begin
      if (cyc == inc_edge) m_a = m_a + 32'd1;
      if (cyc > fsm_end + 1 && mq.size() > 0) begin
        m_e = mq.pop_front();
        case (m_e[10:8])
          3'd0, 3'd1, 3'd2, 3'd3: m_a[8*m_e[10:8] +: 8] = m_e[7:0];
          3'd4: if (m_act) begin
            m_d = m_e[7:0];
            wr_start = cyc;
            inc_edge = cyc + WR;
            fsm_end = cyc + WR + GAP - 1;
          end
          3'd5: m_act = m_e[0];
          default: ;
        endcase
      end
      if (bus_if.mcu_req && bus_if.mcu_cmd == 8'h0F) begin
        if (bus_if.mcu_addr <= 8'd5) begin
          if (mq.size() < DEPTH) mq.push_back({bus_if.mcu_addr[2:0], bus_if.mcu_data});
          else m_ovf = 1'b1;
        end else if (bus_if.mcu_addr == 8'd6) begin
          m_ovf = 1'b0;
        end
      end
    end
  end

  bit check_en = 1'b0;
  logic prev_wr = 1'b0;
  logic [31:0] log_a[$];
  logic [7:0]  log_d[$];
  int          log_c[$];

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      chk("loader_act", bus_if.loader_act, m_act);
      chk("loader_a",   bus_if.loader_a, m_a);
      chk("loader_d",   bus_if.loader_d, m_d);
      chk("loader_wr",  bus_if.loader_wr, (cyc >= wr_start && cyc < wr_start + WR));
      chk("busy",       bus_if.busy, (mq.size() > 0 || cyc <= fsm_end));
      chk("overflow",   bus_if.overflow, m_ovf);
    end
    if (bus_if.loader_wr && !prev_wr) begin
      log_a.push_back(bus_if.loader_a);
      log_d.push_back(bus_if.loader_d);
      log_c.push_back(cyc);
    end
    prev_wr = bus_if.loader_wr;
  end

  task automatic drive(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_if.mcu_req = 1'b1;
    bus_if.mcu_cmd = c;
    bus_if.mcu_addr = a;
    bus_if.mcu_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus_if.mcu_req = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    idle(1);
    while (bus_if.busy && k < 300) begin
      idle(1);
      k++;
    end
    chk("wait_idle_timeout", bus_if.busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n0;
  int k;

  initial begin
    bus_if.mcu_req = 1'b0;
    bus_if.mcu_cmd = '0;
    bus_if.mcu_addr = '0;
    bus_if.mcu_data = '0;
    reset_n = 1'b0;
    idle(2);
    check_en = 1'b1;
    idle(1);
    chk("rst_a", bus_if.loader_a, 0);
    chk("rst_wr", bus_if.loader_wr, 0);
    chk("rst_busy", bus_if.busy, 0);
    reset_n = 1'b1;
    idle(2);

    // Basic two-byte stream at 0x8000_4000
    n0 = log_a.size();
    drive(8'h0F, 8'h00, 8'h00);
    drive(8'h0F, 8'h01, 8'h40);
    drive(8'h0F, 8'h02, 8'h00);
    drive(8'h0F, 8'h03, 8'h80);
    drive(8'h0F, 8'h05, 8'h01);
    drive(8'h0F, 8'h04, 8'hAA);
    drive(8'h0F, 8'h04, 8'h55);
    wait_idle();
    chk("t1_count", log_a.size() - n0, 2);
    if (log_a.size() >= n0 + 2) begin
      chk("t1_a0", log_a[n0], 32'h8000_4000);
      chk("t1_d0", log_d[n0], 8'hAA);
      chk("t1_a1", log_a[n0+1], 32'h8000_4001);
      chk("t1_d1", log_d[n0+1], 8'h55);
      chk("t1_period", log_c[n0+1] - log_c[n0], 7);
    end
    chk("t1_final_a", bus_if.loader_a, 32'h8000_4002);

    // Address wrap
    n0 = log_a.size();
    for (int i = 0; i < 4; i++) drive(8'h0F, 8'(i), 8'hFF);
    drive(8'h0F, 8'h04, 8'h33);
    wait_idle();
    chk("t2_count", log_a.size() - n0, 1);
    if (log_a.size() > n0) chk("t2_a", log_a[n0], 32'hFFFF_FFFF);
    chk("t2_wrap", bus_if.loader_a, 32'h0000_0000);

    // Inactive loader discards data
    n0 = log_a.size();
    drive(8'h0F, 8'h05, 8'h00);
    drive(8'h0F, 8'h04, 8'h12);
    wait_idle();
    chk("t3_no_strobe", log_a.size() - n0, 0);
    chk("t3_a", bus_if.loader_a, 32'h0);
    chk("t3_busy", bus_if.busy, 0);

    // Overflow with six back-to-back data bytes
    drive(8'h0F, 8'h05, 8'h01);
    wait_idle();
    n0 = log_a.size();
    for (int i = 0; i < 6; i++) drive(8'h0F, 8'h04, 8'(8'h10 + i));
    idle(1);
    chk("t4_ovf_set", bus_if.overflow, 1);
    wait_idle();
    chk("t4_count", log_a.size() - n0, 5);
    if (log_a.size() >= n0 + 5) chk("t4_last_d", log_d[n0+4], 8'h14);
    chk("t4_ovf_sticky", bus_if.overflow, 1);
    drive(8'h0F, 8'h06, 8'h00);
    idle(1);
    chk("t4_ovf_clr", bus_if.overflow, 0);

    // Reset during second strobe cycle
    drive(8'h0F, 8'h04, 8'h77);
    k = 0;
    while (!bus_if.loader_wr && k < 20) begin
      idle(1);
      k++;
    end
    chk("t5_strobe_seen", bus_if.loader_wr, 1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t5_wr", bus_if.loader_wr, 0);
    chk("t5_a", bus_if.loader_a, 0);
    chk("t5_act", bus_if.loader_act, 0);
    chk("t5_busy", bus_if.busy, 0);
    reset_n = 1'b1;
    n0 = log_a.size();
    idle(20);
    chk("t5_no_more", log_a.size() - n0, 0);

    // Foreign command is ignored
    n0 = log_a.size();
    drive(8'h01, 8'h04, 8'h99);
    idle(3);
    chk("t6_busy", bus_if.busy, 0);
    chk("t6_d", bus_if.loader_d, 0);
    chk("t6_no_strobe", log_a.size() - n0, 0);

    // Randomized traffic checked every cycle by the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        logic [7:0] c, a, d;
        c = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h0F;
        a = ($urandom_range(0, 2) == 0) ? 8'h04 : 8'($urandom_range(0, 7));
        d = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        drive(c, a, d);
      end else begin
        idle(1);
      end
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
